// File: rtl/ins_mem_pkg.sv
// rtl/ins_mem_pkg.sv - shared types, constants and parity helper for the loadable instruction memory
package ins_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } ins_mem_state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // widest word the parity helper accepts; callers zero-extend into it
  localparam int PARITY_MAX_W = 1024;

  // even parity: the returned bit makes the total count of ones even
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/ins_mem_byte_packer.sv
// rtl/ins_mem_byte_packer.sv - assembles an MSB-first byte stream into instruction words
module ins_mem_byte_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  input  logic              flush,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [LANE_W-1:0] lane, lane_n;
  logic [DATA_W-1:0] shreg, sh_n;
  logic [DATA_W+7:0] cat;

  // shift the byte in first, then apply a flush to whatever is left over
  always_comb begin
    cat        = {shreg, byte_in};
    sh_n       = shreg;
    lane_n     = lane;
    word       = '0;
    word_valid = 1'b0;
    if (byte_valid) begin
      sh_n = cat[DATA_W-1:0];
      if (lane == LANE_W'(BYTES - 1)) begin
        word       = sh_n;
        word_valid = 1'b1;
        lane_n     = '0;
      end else begin
        lane_n = lane + 1'b1;
      end
    end
    if (flush && (lane_n != '0)) begin
      // move the partial bytes to the top and zero-fill the low lanes
      word       = sh_n << (8 * (BYTES - int'(lane_n)));
      word_valid = 1'b1;
      lane_n     = '0;
    end
  end

  // lane counter and assembly register; clear drops any partial word
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane  <= '0;
      shreg <= '0;
    end else begin
      lane  <= lane_n;
      shreg <= sh_n;
    end
  end

endmodule

// File: rtl/ins_mem_loadable.sv
// rtl/ins_mem_loadable.sv - run-time loadable instruction memory with registered fetch; INS_MEM_PARITY_EN adds parity
module ins_mem_loadable
  import ins_mem_pkg::*;
#(
  parameter int               DEPTH     = 256,
  parameter int               DATA_W    = 32,
  parameter logic [31:0]      BASE_ADDR = 32'h0000_0000,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic [DATA_W-1:0] inst_out,
  output logic              inst_valid,
  output logic              addr_fault,
  input  logic              load_start,
  input  logic              load_byte_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_done,
  output logic              load_busy,
  output logic [$clog2(DEPTH):0] load_count,
  output logic              load_ovf
`ifdef INS_MEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int          ADDR_W    = $clog2(DEPTH);
  localparam int          BYTES     = DATA_W / 8;
  localparam int          LANE_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH * BYTES);

  ins_mem_state_t    state;
  logic [ADDR_W:0]   wptr;
  logic              full;
  logic              in_load;
  logic              pk_byte_valid;
  logic              pk_flush;
  logic [DATA_W-1:0] pk_word;
  logic              pk_word_valid;
  logic              we;
  logic [31:0]       off;
  logic [ADDR_W-1:0] fetch_idx;
  logic              fault;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef INS_MEM_PARITY_EN
  logic              mem_par [DEPTH];
`endif

  assign in_load    = (state == LOAD);
  assign full       = (wptr == (ADDR_W + 1)'(DEPTH));
  assign load_count = wptr;

  // a load_start always wins over bytes and done in the same cycle
  assign pk_byte_valid = in_load && load_byte_valid && !load_start && !full;
  assign pk_flush      = in_load && load_done && !load_start;
  assign we            = pk_word_valid && !full;

  assign off       = fetch_addr - BASE_ADDR;
  assign fetch_idx = off[LANE_W +: ADDR_W];
  assign fault     = (off[LANE_W-1:0] != '0) || (off >= MEM_BYTES);

  ins_mem_byte_packer #(
    .DATA_W(DATA_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_start),
    .byte_valid(pk_byte_valid),
    .byte_in   (load_byte),
    .flush     (pk_flush),
    .word      (pk_word),
    .word_valid(pk_word_valid)
  );

  // load FSM: owns the write pointer, busy flag and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wptr      <= '0;
      load_ovf  <= 1'b0;
      load_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state     <= LOAD;
            load_busy <= 1'b1;
            wptr      <= '0;
            load_ovf  <= 1'b0;
          end
        end
        LOAD: begin
          if (load_start) begin
            wptr     <= '0;
            load_ovf <= 1'b0;
          end else begin
            if (we) wptr <= wptr + 1'b1;
            if (load_byte_valid && full) load_ovf <= 1'b1;
            if (load_done) begin
              state     <= IDLE;
              load_busy <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          load_busy <= 1'b0;
        end
      endcase
    end
  end

  // array write port; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wptr[ADDR_W-1:0]] <= pk_word;
`ifdef INS_MEM_PARITY_EN
      mem_par[wptr[ADDR_W-1:0]] <= even_parity(PARITY_MAX_W'(pk_word));
`endif
    end
  end

  // registered fetch port, only served outside of LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_out   <= '0;
      inst_valid <= 1'b0;
      addr_fault <= 1'b0;
`ifdef INS_MEM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (!in_load && fetch_req) begin
      inst_valid <= 1'b1;
      addr_fault <= fault;
      inst_out   <= fault ? NOP_WORD : mem[fetch_idx];
`ifdef INS_MEM_PARITY_EN
      parity_err <= !fault &&
                    (even_parity(PARITY_MAX_W'(mem[fetch_idx])) != mem_par[fetch_idx]);
`endif
    end else begin
      inst_valid <= 1'b0;
      addr_fault <= 1'b0;
`ifdef INS_MEM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_ins_mem_loadable.sv
// tb/tb_ins_mem_loadable.sv - scoreboard bench for ins_mem_loadable (main DEPTH=256, small DEPTH=2)
module tb_ins_mem_loadable;

  typedef struct packed {
    logic        fault;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] inst_out;
  logic        inst_valid, addr_fault;
  logic        load_start, load_byte_valid, load_done;
  logic [7:0]  load_byte;
  logic        load_busy, load_ovf;
  logic [8:0]  load_count;

  logic        s_fetch_req;
  logic [31:0] s_fetch_addr;
  logic [31:0] s_inst_out;
  logic        s_inst_valid, s_addr_fault;
  logic        s_load_start, s_load_byte_valid, s_load_done;
  logic [7:0]  s_load_byte;
  logic        s_load_busy, s_load_ovf;
  logic [1:0]  s_load_count;
`ifdef INS_MEM_PARITY_EN
  logic        parity_err, s_parity_err;
`endif

  int   pass_cnt = 0;
  int   total    = 0;
  exp_t sb[$];
  exp_t e;

  ins_mem_loadable #(.DEPTH(256), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .inst_out(inst_out), .inst_valid(inst_valid), .addr_fault(addr_fault),
    .load_start(load_start), .load_byte_valid(load_byte_valid), .load_byte(load_byte),
    .load_done(load_done), .load_busy(load_busy), .load_count(load_count),
    .load_ovf(load_ovf)
`ifdef INS_MEM_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  ins_mem_loadable #(.DEPTH(2), .DATA_W(32)) dut_small (
    .clk(clk), .rst(rst), .fetch_req(s_fetch_req), .fetch_addr(s_fetch_addr),
    .inst_out(s_inst_out), .inst_valid(s_inst_valid), .addr_fault(s_addr_fault),
    .load_start(s_load_start), .load_byte_valid(s_load_byte_valid), .load_byte(s_load_byte),
    .load_done(s_load_done), .load_busy(s_load_busy), .load_count(s_load_count),
    .load_ovf(s_load_ovf)
`ifdef INS_MEM_PARITY_EN
    , .parity_err(s_parity_err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_byte_valid = 1'b1;
    load_byte       = b;
    tick();
    load_byte_valid = 1'b0;
  endtask

  task automatic fetch_main(input logic [31:0] a, input logic f, input logic c, input logic [31:0] d);
    sb.push_back('{fault: f, chk: c, data: d});
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
  endtask

  task automatic fetch_small(input logic [31:0] a, input logic f, input logic c, input logic [31:0] d);
    sb.push_back('{fault: f, chk: c, data: d});
    s_fetch_req  = 1'b1;
    s_fetch_addr = a;
    tick();
    s_fetch_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if (inst_valid !== 1'b0 || addr_fault !== 1'b0 || inst_out !== 32'h0)
      $display("FAIL reset_fetch_regs: valid=%b fault=%b inst=%h want 0 0 00000000", inst_valid, addr_fault, inst_out);
    else pass_cnt++;
    total++;
    if (load_busy !== 1'b0 || load_count !== 9'd0 || load_ovf !== 1'b0)
      $display("FAIL reset_load_regs: busy=%b count=%0d ovf=%b want 0 0 0", load_busy, load_count, load_ovf);
    else pass_cnt++;
    fetch_main(32'h0, 1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || addr_fault !== e.fault)
      $display("FAIL reset_first_fetch: valid=%b fault=%b want 1 %b", inst_valid, addr_fault, e.fault);
    else pass_cnt++;
    total++;
    if (load_busy !== 1'b0 || load_count !== 9'd0)
      $display("FAIL reset_after_fetch: busy=%b count=%0d want 0 0", load_busy, load_count);
    else pass_cnt++;
  endtask

  task automatic test_load_and_fetch();
    logic [7:0]  img [8] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
    logic [31:0] exp_w [2] = '{32'h8C01_0004, 32'h0022_1820};
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    total++;
    if (load_busy !== 1'b1)
      $display("FAIL load_busy_set: got %b want 1", load_busy);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) send_byte(img[i]);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    total++;
    if (load_count !== 9'd2 || load_busy !== 1'b0)
      $display("FAIL load_two_words: count=%0d busy=%b want 2 0", load_count, load_busy);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      fetch_main(32'(i * 4), 1'b0, 1'b1, exp_w[i]);
      e = sb.pop_front();
      total++;
      if (inst_valid !== 1'b1 || addr_fault !== e.fault || inst_out !== e.data)
        $display("FAIL fetch_word%0d: valid=%b fault=%b inst=%h want 1 %b %h", i, inst_valid, addr_fault, inst_out, e.fault, e.data);
      else pass_cnt++;
    end
    tick();
    total++;
    if (inst_valid !== 1'b0 || addr_fault !== 1'b0 || inst_out !== 32'h0022_1820)
      $display("FAIL fetch_idle_hold: valid=%b fault=%b inst=%h want 0 0 00221820", inst_valid, addr_fault, inst_out);
    else pass_cnt++;
  endtask

  task automatic test_fetch_faults();
    logic [31:0] addrs [3] = '{32'h0000_0002, 32'h0000_0400, 32'h0000_03FC};
    logic        faults [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      fetch_main(addrs[i], faults[i], faults[i], 32'h0);
      e = sb.pop_front();
      total++;
      if (inst_valid !== 1'b1 || addr_fault !== e.fault || (e.chk && inst_out !== e.data))
        $display("FAIL fault_addr_%h: valid=%b fault=%b inst=%h want 1 %b %h", addrs[i], inst_valid, addr_fault, inst_out, e.fault, e.data);
      else pass_cnt++;
    end
  endtask

  task automatic test_partial_and_restart();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    total++;
    if (load_count !== 9'd1)
      $display("FAIL partial_count: got %0d want 1", load_count);
    else pass_cnt++;
    fetch_main(32'h0, 1'b0, 1'b1, 32'hAABB_CC00);
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || inst_out !== e.data)
      $display("FAIL partial_pad: valid=%b inst=%h want 1 %h", inst_valid, inst_out, e.data);
    else pass_cnt++;

    // restart discards the partial word; last byte arrives together with done
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    load_start = 1'b1;
    load_done  = 1'b1;
    tick();
    load_start = 1'b0;
    load_done  = 1'b0;
    total++;
    if (load_busy !== 1'b1 || load_count !== 9'd0)
      $display("FAIL restart_wins: busy=%b count=%0d want 1 0", load_busy, load_count);
    else pass_cnt++;
    fetch_main(32'h0, 1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b0)
      $display("FAIL fetch_in_load: valid=%b want 0", inst_valid);
    else pass_cnt++;
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h55); send_byte(8'h66);
    load_byte_valid = 1'b1;
    load_byte       = 8'h77;
    load_done       = 1'b1;
    tick();
    load_byte_valid = 1'b0;
    load_done       = 1'b0;
    total++;
    if (load_count !== 9'd2 || load_busy !== 1'b0)
      $display("FAIL byte_with_done: count=%0d busy=%b want 2 0", load_count, load_busy);
    else pass_cnt++;
    fetch_main(32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    e = sb.pop_front();
    total++;
    if (inst_out !== e.data)
      $display("FAIL restart_word0: inst=%h want %h", inst_out, e.data);
    else pass_cnt++;
    fetch_main(32'h4, 1'b0, 1'b1, 32'h5566_7700);
    e = sb.pop_front();
    total++;
    if (inst_out !== e.data)
      $display("FAIL restart_word1: inst=%h want %h", inst_out, e.data);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    s_load_start = 1'b1;
    tick();
    s_load_start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_load_byte_valid = 1'b1;
      s_load_byte       = 8'(i);
      tick();
    end
    s_load_byte_valid = 1'b0;
    total++;
    if (s_load_count !== 2'd2 || s_load_ovf !== 1'b1 || s_load_busy !== 1'b1)
      $display("FAIL ovf_flags: count=%0d ovf=%b busy=%b want 2 1 1", s_load_count, s_load_ovf, s_load_busy);
    else pass_cnt++;
    fetch_small(32'h0, 1'b0, 1'b0, 32'h0);
    e = sb.pop_front();
    total++;
    if (s_inst_valid !== 1'b0)
      $display("FAIL small_fetch_in_load: valid=%b want 0", s_inst_valid);
    else pass_cnt++;
    s_load_done = 1'b1;
    tick();
    s_load_done = 1'b0;
    fetch_small(32'h0, 1'b0, 1'b1, 32'h0001_0203);
    e = sb.pop_front();
    total++;
    if (s_inst_valid !== 1'b1 || s_inst_out !== e.data)
      $display("FAIL ovf_word0: valid=%b inst=%h want 1 %h", s_inst_valid, s_inst_out, e.data);
    else pass_cnt++;
    fetch_small(32'h4, 1'b0, 1'b1, 32'h0405_0607);
    e = sb.pop_front();
    total++;
    if (s_inst_out !== e.data || s_addr_fault !== e.fault)
      $display("FAIL ovf_word1: inst=%h fault=%b want %h %b", s_inst_out, s_addr_fault, e.data, e.fault);
    else pass_cnt++;
    fetch_small(32'h8, 1'b1, 1'b1, 32'h0);
    e = sb.pop_front();
    total++;
    if (s_addr_fault !== e.fault || s_inst_out !== e.data)
      $display("FAIL small_range: fault=%b inst=%h want %b %h", s_addr_fault, s_inst_out, e.fault, e.data);
    else pass_cnt++;
  endtask

  task automatic test_reset_during_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
    send_byte(8'h11); send_byte(8'h22);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (load_busy !== 1'b0 || load_count !== 9'd0 || load_ovf !== 1'b0)
      $display("FAIL rst_in_load: busy=%b count=%0d ovf=%b want 0 0 0", load_busy, load_count, load_ovf);
    else pass_cnt++;
    fetch_main(32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
    e = sb.pop_front();
    total++;
    if (inst_valid !== 1'b1 || inst_out !== e.data)
      $display("FAIL rst_keeps_word0: valid=%b inst=%h want 1 %h", inst_valid, inst_out, e.data);
    else pass_cnt++;
`ifdef INS_MEM_PARITY_EN
    total++;
    if (parity_err !== 1'b0)
      $display("FAIL parity_clean: got %b want 0", parity_err);
    else pass_cnt++;
    dut.mem[0] = dut.mem[0] ^ 32'h0000_0008;
    fetch_main(32'h0, 1'b0, 1'b1, 32'hCAFE_F005);
    e = sb.pop_front();
    total++;
    if (parity_err !== 1'b1 || inst_out !== e.data)
      $display("FAIL parity_flip: perr=%b inst=%h want 1 %h", parity_err, inst_out, e.data);
    else pass_cnt++;
`endif
  endtask

  initial begin
    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = 32'h0;
    load_start = 1'b0; load_byte_valid = 1'b0; load_byte = 8'h0; load_done = 1'b0;
    s_fetch_req = 1'b0; s_fetch_addr = 32'h0;
    s_load_start = 1'b0; s_load_byte_valid = 1'b0; s_load_byte = 8'h0; s_load_done = 1'b0;
    test_reset();
    test_load_and_fetch();
    test_fetch_faults();
    test_partial_and_restart();
    test_overflow();
    test_reset_during_load();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
